rv32i_instr_encoder: RTL

- Encoder counterpart of the pd fetch/decode stage.
- Accepts decoded RV32I fields (op, rd, rs1, rs2, funct3, funct7, imm, shamt) and packs them into a 32-bit instruction word.
- Outputs each word with a sequential word address, for loading imemory or feeding the decoder in testbenches.
- 2-stage elastic valid/ready pipeline; illegal field combinations are dropped and flagged.

---
 rtl/rv32i_instr_encoder.sv | 115 +++++++++++
 1 files changed

// File: rtl/rv32i_instr_encoder.sv
// rv32i_instr_encoder: packs decoded RV32I fields into instruction words with sequential addresses.
// Two-stage valid/ready pipeline; illegal bundles are dropped in S1 and flagged.
module rv32i_instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
    parameter bit          CHECK_IMM = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    input  logic [4:0]  shamt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [31:0] out_addr,
    output logic        err_pulse,
    output logic        err_sticky,
    output logic [15:0] word_count
);
    logic        s1_valid, s1_legal, s1_adv, xfer, legal;
    logic [31:0] s1_word, word;
    logic        i_ok, b_ok, j_ok, u_ok, shift, sh_ok;

    assign i_ok  = !CHECK_IMM || &imm[31:11] || ~|imm[31:11];
    assign b_ok  = !CHECK_IMM || ((&imm[31:12] || ~|imm[31:12]) && !imm[0]);
    assign j_ok  = !CHECK_IMM || ((&imm[31:20] || ~|imm[31:20]) && !imm[0]);
    assign u_ok  = !CHECK_IMM || ~|imm[11:0];
    assign shift = funct3 == 3'b001 || funct3 == 3'b101;
    assign sh_ok = funct7 == 7'b0000000 || (funct7 == 7'b0100000 && funct3 == 3'b101);

    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (op)
            7'b0110011: begin
                word  = {funct7, rs2, rs1, funct3, rd, op};
                legal = 1'b1;
            end
            7'b0000011, 7'b1100111: begin
                word  = {imm[11:0], rs1, funct3, rd, op};
                legal = i_ok;
            end
            7'b0010011: begin
                word  = shift ? {funct7, shamt, rs1, funct3, rd, op} : {imm[11:0], rs1, funct3, rd, op};
                legal = shift ? sh_ok : i_ok;
            end
            7'b0100011: begin
                word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
                legal = i_ok;
            end
            7'b1100011: begin
                word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
                legal = b_ok;
            end
            7'b0110111, 7'b0010111: begin
                word  = {imm[31:12], rd, op};
                legal = u_ok;
            end
            7'b1101111: begin
                word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                legal = j_ok;
            end
            7'b1110011: begin
                word  = {imm[11:0], 13'b0, op};
                legal = ~|imm[31:1];
            end
            default: ;
        endcase
    end

    // An illegal bundle always leaves S1 so it never stalls the stream behind it.
    assign xfer     = out_valid && out_ready;
    assign s1_adv   = s1_valid && (!s1_legal || !out_valid || out_ready);
    assign in_ready = !s1_valid || s1_adv;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_legal   <= 1'b0;
            s1_word    <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_addr   <= BASE_ADDR;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            word_count <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                s1_legal <= legal;
                s1_word  <= word;
            end
            if (s1_adv && s1_legal) begin
                out_valid <= 1'b1;
                out_data  <= s1_word;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
            err_pulse <= s1_valid && !s1_legal;
            if (s1_valid && !s1_legal)
                err_sticky <= 1'b1;
            if (xfer) begin
                out_addr   <= out_addr + 32'd4;
                word_count <= &word_count ? word_count : word_count + 16'd1;
            end
        end
    end
endmodule
